// File: rtl/pkg_ooo.sv
// Shared out-of-order core definitions: default sizing, source-operand indexing and the
// issue-queue entry record used by rename, the busy table and the issue queue.
package pkg_ooo;

  localparam int unsigned DEF_NUM_PHYS_REGS = 64;
  localparam int unsigned DEF_NUM_ENTRIES   = 16;
  localparam int unsigned DEF_PAYLOAD_WIDTH = 64;
  localparam int unsigned LOG_PHYS          = $clog2(DEF_NUM_PHYS_REGS);
  localparam int unsigned LOG_ENT           = $clog2(DEF_NUM_ENTRIES);
  localparam int unsigned NUM_SRCS          = 3;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_C = 2'd2
  } src_sel_e;

  typedef struct packed {
    logic                                valid;
    logic [NUM_SRCS-1:0][LOG_PHYS-1:0]   tag;
    logic [NUM_SRCS-1:0]                 rdy;
    logic [DEF_PAYLOAD_WIDTH-1:0]        payload;
  } iq_entry_t;

  function automatic logic all_ready(input logic [NUM_SRCS-1:0] rdy);
    return &rdy;
  endfunction

endpackage

// File: rtl/iq_pick_lowest.sv
// Lowest-set-bit priority encoder: index of the lowest requesting bit plus a found flag.
module iq_pick_lowest #(
  parameter int unsigned N = 16,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !o_found) begin
        o_found = 1'b1;
        o_idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue buffer: holds renamed uops until all three sources are ready, then
// issues the lowest-index eligible entry per cycle into a registered valid/stall stage.
module issue_queue
  import pkg_ooo::*;
#(
  parameter int unsigned NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
  parameter int unsigned NUM_ENTRIES   = DEF_NUM_ENTRIES,
  parameter int unsigned PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             Flush_IN,
  input  logic                             Dispatch_Valid_IN,
  output logic                             Dispatch_Ready_OUT,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] Dispatch_SrcA_IN,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] Dispatch_SrcB_IN,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] Dispatch_SrcC_IN,
  input  logic                             Dispatch_RdyA_IN,
  input  logic                             Dispatch_RdyB_IN,
  input  logic                             Dispatch_RdyC_IN,
  input  logic [PAYLOAD_WIDTH-1:0]         Dispatch_Payload_IN,
  input  logic                             Wakeup_Valid_IN,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] Wakeup_Tag_IN,
  output logic                             Issue_Valid_OUT,
  input  logic                             Issue_Stall_IN,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] RegAddrA_OUT,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] RegAddrB_OUT,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] RegAddrC_OUT,
  output logic [PAYLOAD_WIDTH-1:0]         Issue_Payload_OUT
);

  localparam int unsigned      TAG_W = $clog2(NUM_PHYS_REGS);
  localparam int unsigned      IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned      CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]   r_valid;
  logic [TAG_W-1:0]         r_tag     [NUM_ENTRIES][NUM_SRCS];
  logic [NUM_SRCS-1:0]      r_rdy     [NUM_ENTRIES];
  logic [PAYLOAD_WIDTH-1:0] r_payload [NUM_ENTRIES];
  logic [CNT_W-1:0]         r_count;
  logic                     r_iss_valid;
  logic [TAG_W-1:0]         r_iss_tag [NUM_SRCS];
  logic [PAYLOAD_WIDTH-1:0] r_iss_payload;

  logic [TAG_W-1:0]         w_src     [NUM_SRCS];
  logic [NUM_SRCS-1:0]      w_src_rdy;
  logic [NUM_SRCS-1:0]      w_disp_rdy;
  logic [NUM_SRCS-1:0]      w_wake    [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   w_elig;
  logic [NUM_ENTRIES-1:0]   w_free;
  logic [IDX_W-1:0]         w_free_idx;
  logic [IDX_W-1:0]         w_sel_idx;
  logic                     w_free_found;
  logic                     w_sel_found;
  logic                     w_accept;
  logic                     w_load_en;
  logic                     w_issue;

  assign w_src[SRC_A]        = Dispatch_SrcA_IN;
  assign w_src[SRC_B]        = Dispatch_SrcB_IN;
  assign w_src[SRC_C]        = Dispatch_SrcC_IN;
  assign w_src_rdy[SRC_A]    = Dispatch_RdyA_IN;
  assign w_src_rdy[SRC_B]    = Dispatch_RdyB_IN;
  assign w_src_rdy[SRC_C]    = Dispatch_RdyC_IN;
  assign w_free              = ~r_valid;

  // Ready comes only from the registered count, so a slot freed this cycle is not reused until next.
  assign Dispatch_Ready_OUT  = (r_count != FULL);
  assign w_accept            = Dispatch_Valid_IN & Dispatch_Ready_OUT & w_free_found;
  assign w_load_en           = ~r_iss_valid | ~Issue_Stall_IN;
  assign w_issue             = w_load_en & w_sel_found;

  // Wakeup CAM: one comparator per entry and source, plus the bypass for the dispatching uop.
  always_comb begin
    w_elig     = '0;
    w_disp_rdy = '0;
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      w_wake[e] = '0;
      w_elig[e] = r_valid[e] & all_ready(r_rdy[e]);
      for (int unsigned s = 0; s < NUM_SRCS; s++) begin
        w_wake[e][s] = Wakeup_Valid_IN & (r_tag[e][s] == Wakeup_Tag_IN);
      end
    end
    for (int unsigned s = 0; s < NUM_SRCS; s++) begin
      w_disp_rdy[s] = w_src_rdy[s] | (Wakeup_Valid_IN & (w_src[s] == Wakeup_Tag_IN));
    end
  end

  iq_pick_lowest #(.N(NUM_ENTRIES), .W(IDX_W)) u_pick_free (
    .i_req   (w_free),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  iq_pick_lowest #(.N(NUM_ENTRIES), .W(IDX_W)) u_pick_sel (
    .i_req   (w_elig),
    .o_idx   (w_sel_idx),
    .o_found (w_sel_found)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid       <= '0;
      r_count       <= '0;
      r_iss_valid   <= 1'b0;
      r_iss_payload <= '0;
      for (int unsigned s = 0; s < NUM_SRCS; s++) r_iss_tag[s] <= '0;
    end else if (Flush_IN) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      if (w_issue)  r_valid[w_sel_idx]  <= 1'b0;
      if (w_accept) r_valid[w_free_idx] <= 1'b1;
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
      if (w_load_en) begin
        r_iss_valid <= w_sel_found;
        if (w_sel_found) begin
          r_iss_payload <= r_payload[w_sel_idx];
          for (int unsigned s = 0; s < NUM_SRCS; s++) r_iss_tag[s] <= r_tag[w_sel_idx][s];
        end
      end
    end
  end

  // Entry contents need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge CLK) begin
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      for (int unsigned s = 0; s < NUM_SRCS; s++) begin
        if (r_valid[e] && w_wake[e][s]) r_rdy[e][s] <= 1'b1;
      end
    end
    if (w_accept && !Flush_IN && !RESET) begin
      r_rdy[w_free_idx]     <= w_disp_rdy;
      r_payload[w_free_idx] <= Dispatch_Payload_IN;
      for (int unsigned s = 0; s < NUM_SRCS; s++) r_tag[w_free_idx][s] <= w_src[s];
    end
  end

  assign Issue_Valid_OUT   = r_iss_valid;
  assign RegAddrA_OUT      = r_iss_tag[SRC_A];
  assign RegAddrB_OUT      = r_iss_tag[SRC_B];
  assign RegAddrC_OUT      = r_iss_tag[SRC_C];
  assign Issue_Payload_OUT = r_iss_payload;

endmodule
